// File: rtl/hub75_rx_if.sv
// hub75_rx_if: HUB75 pin bundle between a panel controller and hub75_rx.
// master drives clk/lat/oe_n/addr/rgb0/rgb1; slave samples them.
interface hub75_rx_if #(
    parameter int ROW_BITS = 5
);
    logic                hub_clk;
    logic                hub_lat;
    logic                hub_oe_n;
    logic [ROW_BITS-1:0] hub_addr;
    logic [2:0]          hub_rgb0;
    logic [2:0]          hub_rgb1;

    modport master (
        output hub_clk, hub_lat, hub_oe_n,
        output hub_addr, hub_rgb0, hub_rgb1
    );

    modport slave (
        input hub_clk, hub_lat, hub_oe_n,
        input hub_addr, hub_rgb0, hub_rgb1
    );
endinterface

// File: rtl/hub75_rx.sv
// hub75_rx: HUB75 receiver. Rebuilds latched rows into frame-buffer writes.
// Ports: clk, rst (async high), hub (slave pins), wr_* write port, row/plane/
// on-time status, frame_start pulse, sticky err_len/err_ovf.
module hub75_rx #(
    parameter int NUM_COLS = 64,
    parameter int COL_BITS = 6,
    parameter int ROW_BITS = 5,
    parameter int ON_BITS  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    hub75_rx_if.slave                  hub,
    output logic                       wr_en_o,
    output logic [ROW_BITS+COL_BITS:0] wr_addr_o,
    output logic [2:0]                 wr_data_o,
    output logic                       row_done_o,
    output logic [ROW_BITS-1:0]        row_addr_o,
    output logic [2:0]                 plane_idx_o,
    output logic [ON_BITS-1:0]         on_cycles_o,
    output logic                       frame_start_o,
    output logic                       err_len_o,
    output logic                       err_ovf_o
);
    localparam int SW = ROW_BITS + 9;
    // oe_n resets high so no OE time is counted while the sync fills.
    localparam logic [SW-1:0] SYNC_RST = SW'(1) << (ROW_BITS + 6);
    localparam logic [COL_BITS:0]   K_MAX    = (COL_BITS+1)'(NUM_COLS);
    localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(NUM_COLS - 1);
    localparam logic [ON_BITS-1:0]  ON_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE, DUMP_TOP, DUMP_BOT, DONE
    } state_t;

    logic [SW-1:0]       sync1_q, sync2_q;
    logic                clk_prev_q, lat_prev_q;
    logic [5:0]          line_q [2][NUM_COLS];
    logic                fill_q;
    logic [COL_BITS:0]   k_q;
    state_t              state_q, state_d;
    logic [COL_BITS-1:0] col_q, col_d;
    logic [ROW_BITS-1:0] row_addr_q, prev_addr_q;
    logic [2:0]          plane_q;
    logic [ON_BITS-1:0]  on_cnt_q, on_cycles_q;
    logic                frame_start_q, err_len_q, err_ovf_q;

    logic                clk_s, lat_s, oe_n_s;
    logic [ROW_BITS-1:0] addr_s;
    logic [5:0]          pix_s;
    logic                shift_rise, lat_rise, shift_ok, accept;
    logic [COL_BITS:0]   k_eff;
    logic [COL_BITS-1:0] fill_col;
    logic [5:0]          dump_pix;
    logic                wr_en, half, row_done;

    assign {clk_s, lat_s, oe_n_s, addr_s, pix_s} = sync2_q;

    assign shift_rise = clk_s & ~clk_prev_q;
    assign lat_rise   = lat_s & ~lat_prev_q;
    assign shift_ok   = shift_rise && (k_q < K_MAX);
    // A shift in the latch cycle still belongs to the row being latched.
    assign k_eff      = k_q + {{COL_BITS{1'b0}}, shift_ok};
    assign accept     = lat_rise && (state_q == IDLE);
    // First pixel shifted ends up in the last column.
    assign fill_col   = COL_BITS'(K_MAX - (COL_BITS+1)'(1) - k_q);
    assign dump_pix   = line_q[~fill_q][col_q];

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        wr_en    = 1'b0;
        half     = 1'b0;
        row_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = DUMP_TOP;
                    col_d   = '0;
                end
            end
            DUMP_TOP: begin
                wr_en = 1'b1;
                col_d = col_q + 1'b1;
                if (col_q == LAST_COL) begin
                    col_d   = '0;
                    state_d = DUMP_BOT;
                end
            end
            DUMP_BOT: begin
                wr_en = 1'b1;
                half  = 1'b1;
                col_d = col_q + 1'b1;
                if (col_q == LAST_COL) begin
                    col_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                row_done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q       <= SYNC_RST;
            sync2_q       <= SYNC_RST;
            clk_prev_q    <= 1'b0;
            lat_prev_q    <= 1'b0;
            for (int b = 0; b < 2; b++)
                for (int c = 0; c < NUM_COLS; c++)
                    line_q[b][c] <= '0;
            fill_q        <= 1'b0;
            k_q           <= '0;
            state_q       <= IDLE;
            col_q         <= '0;
            row_addr_q    <= '0;
            prev_addr_q   <= '1;
            plane_q       <= '0;
            on_cnt_q      <= '0;
            on_cycles_q   <= '0;
            frame_start_q <= 1'b0;
            err_len_q     <= 1'b0;
            err_ovf_q     <= 1'b0;
        end else begin
            sync1_q       <= {hub.hub_clk, hub.hub_lat, hub.hub_oe_n,
                              hub.hub_addr, hub.hub_rgb1, hub.hub_rgb0};
            sync2_q       <= sync1_q;
            clk_prev_q    <= clk_s;
            lat_prev_q    <= lat_s;
            state_q       <= state_d;
            col_q         <= col_d;
            frame_start_q <= 1'b0;

            if (shift_ok)
                line_q[fill_q][fill_col] <= pix_s;

            if (lat_rise)
                k_q <= '0;
            else if (shift_ok)
                k_q <= k_q + 1'b1;

            if (lat_rise && !accept)
                err_ovf_q <= 1'b1;

            if (accept) begin
                fill_q      <= ~fill_q;
                row_addr_q  <= addr_s;
                prev_addr_q <= addr_s;
                if (k_eff != K_MAX)
                    err_len_q <= 1'b1;
                if (addr_s == prev_addr_q)
                    plane_q <= (plane_q == 3'd7) ? 3'd7 : plane_q + 3'd1;
                else
                    plane_q <= 3'd0;
                frame_start_q <= (addr_s == '0) && (prev_addr_q != '0);
                on_cycles_q   <= on_cnt_q;
                on_cnt_q      <= '0;
            end else if (!oe_n_s && on_cnt_q != ON_MAX) begin
                on_cnt_q <= on_cnt_q + 1'b1;
            end
        end
    end

    assign wr_en_o       = wr_en;
    assign wr_addr_o     = wr_en ? {half, row_addr_q, col_q} : '0;
    assign wr_data_o     = !wr_en ? 3'b000 :
                           half ? dump_pix[5:3] : dump_pix[2:0];
    assign row_done_o    = row_done;
    assign row_addr_o    = row_addr_q;
    assign plane_idx_o   = plane_q;
    assign on_cycles_o   = on_cycles_q;
    assign frame_start_o = frame_start_q;
    assign err_len_o     = err_len_q;
    assign err_ovf_o     = err_ovf_q;
endmodule

// File: doc/hub75_rx.md
Name: hub75_rx

Overview:
- HUB75 panel-side receiver/monitor. Samples the HUB75 pins (RGB0/RGB1 data, pixel clock, latch, OE_n, row address) produced by the panel controller FSM, and rebuilds each latched row into frame-buffer writes.
- Used in loopback self-test and in simulation to check controller output against the source frame.
- Also reports per-latch bit-plane index, OE-on duration, and protocol errors.

Parameters:
- NUM_COLS, 64, pixels shifted per row.
- COL_BITS, 6, width of column index (clog2 NUM_COLS).
- ROW_BITS, 5, width of hub_addr (rows per half-panel = 2^ROW_BITS).
- ON_BITS, 16, width of OE-on cycle counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- hub_clk  in  1  HUB75 pixel clock (async to clk).
- hub_lat  in  1  HUB75 latch.
- hub_oe_n  in  1  HUB75 output enable, active low.
- hub_addr  in  ROW_BITS  HUB75 row address.
- hub_rgb0  in  3  top-half pixel {R,G,B}.
- hub_rgb1  in  3  bottom-half pixel {R,G,B}.
- wr_en  out  1  frame-buffer write strobe.
- wr_addr  out  1+ROW_BITS+COL_BITS  {half, row, col}; half=0 top.
- wr_data  out  3  {R,G,B}.
- row_done  out  1  one-cycle pulse after the last write of a row.
- row_addr  out  ROW_BITS  hub_addr captured at the last latch.
- plane_idx  out  3  bit-plane index of the last latch.
- on_cycles  out  ON_BITS  clk cycles with OE_n low between the previous two latches.
- frame_start  out  1  one-cycle pulse, first latch of a frame.
- err_len  out  1  sticky; latch received with shift count != NUM_COLS.
- err_ovf  out  1  sticky; latch received while the dump bank was still busy.

Behaviour:
- Reset values: all outputs 0. Line buffers cleared. Column count 0. prev_addr all ones. FSM IDLE. Async assert aborts any dump; wr_en drops immediately.
- Input sync: every hub_* input passes a 2-flop synchronizer. Rise detectors run on synced hub_clk and hub_lat. Data is sampled from the synced stage in the cycle the hub_clk rise is detected. Each hub_clk high and low phase must last at least 3 clk cycles.
- Shift capture: on each hub_clk rise, {rgb1,rgb0} is written into the fill bank at column NUM_COLS-1-k, where k is the shift count since the last latch. k saturates at NUM_COLS. Extra shifts are discarded.
- Latch: on a hub_lat rise, the following happen in one cycle:
  - err_len is set if k != NUM_COLS.
  - hub_addr is captured into row_addr.
  - The banks swap: fill bank becomes dump bank.
  - k is reset to 0.
  - Unshifted columns keep stale data.
- Simultaneous hub_clk rise and hub_lat rise in the same cycle: the shift counts toward the row being latched.
- Ping-pong: if a latch arrives while the FSM is not IDLE, err_ovf is set. That latch is ignored completely: no swap, no row_addr/plane_idx/on_cycles update. k is still reset.
- Dump FSM:
  - IDLE → DUMP_TOP on an accepted latch.
  - DUMP_TOP: NUM_COLS cycles, wr_en=1, half=0, col 0..N-1, data = rgb0 entry.
  - DUMP_BOT: NUM_COLS cycles, half=1, col 0..N-1, data = rgb1 entry.
  - DONE: 1 cycle, row_done=1 → IDLE.
  - Timing: latch detected at cycle T gives the first wr_en at T+1 and row_done at T+1+2*NUM_COLS.
- plane_idx: if the accepted latch addr == prev_addr, plane_idx increments, saturating at 7; otherwise it goes to 0. prev_addr then updates to the latch addr.
- frame_start: pulses on an accepted latch with addr == 0 and prev_addr != 0. After reset, the first latch at addr 0 pulses it.
- on_cycles: an internal counter increments each clk while synced oe_n == 0, saturating at 2^ON_BITS-1. On an accepted latch, the count is copied to on_cycles and the counter clears.
- err flags clear only on rst.

Test Plan:
- Reset, shift 64 pixels with rgb0=3'b100 and rgb1=3'b001 for shift k<8 (zeros otherwise), then latch with addr=5:
  - 128 writes.
  - Top cols 56..63 carry 3'b100; bottom cols 56..63 carry 3'b001; all other writes carry 0.
  - row_addr=5, plane_idx=0, row_done 129 cycles after latch detect.
- Three consecutive 64-shift latches at addr=2, then one at addr=3 → plane_idx 0,1,2 then 0.
- Hold oe_n low 200 clk between two latches → on_cycles=200 at the second latch. Hold 70000 cycles → on_cycles=65535.
- Shift 63 then latch → err_len=1. Shift 70 then latch → 128 writes; first 64 shifts stored, extras discarded.
- Two latches 20 clk apart (first dump busy) → err_ovf=1. Second latch ignored; row_addr keeps the first addr.
- After reset, latch sequence addr 0,1,...,31,0 → frame_start pulses twice. Assert rst mid-DUMP_TOP → wr_en=0 immediately, all outputs 0.
